// File: rtl/sun_path_if.sv
// Beam/control in, rendered colour and sequencer status out, between the timing generator and sun_path_engine.
interface sun_path_if #(
    parameter int XW    = 10,
    parameter int YW    = 9,
    parameter int COLRW = 12
);
    logic             frame;
    logic [XW-1:0]    sx;
    logic [YW-1:0]    sy;
    logic             start;
    logic             direction;
    logic [3:0]       speed;
    logic [COLRW-1:0] sun_colr;
    logic             busy;
    logic             done;
    logic [1:0]       phase;

    modport master (output frame, sx, sy, start, direction, speed,
                    input  sun_colr, busy, done, phase);
    modport slave  (input  frame, sx, sy, start, direction, speed,
                    output sun_colr, busy, done, phase);
endinterface

// File: rtl/sun_path_engine.sv
// Animated sun: rise/hold/set sequencer stepping once per (speed+1) frames plus a 2-stage disc renderer.
// Optional halo ring enabled by defining SUN_HALO_EN.
module sun_path_engine #(
    parameter int               XW         = 10,
    parameter int               YW         = 9,
    parameter int               COLRW      = 12,
    parameter int               H_RES      = 640,
    parameter int               V_RES      = 480,
    parameter int               RADIUS     = 24,
    parameter logic [COLRW-1:0] COLOR_SUN  = 'hFF0,
    parameter int               START_X    = 640,
    parameter int               HORIZON_Y  = 310,
    parameter int               STEP_X     = 2,
    parameter int               STEP_Y     = 5,
    parameter int               RISE_STEPS = 40,
    parameter int               HOLD_STEPS = 160
`ifdef SUN_HALO_EN
   ,parameter int               HALO_W     = 4,
    parameter logic [COLRW-1:0] COLOR_HALO = 'h860
`endif
) (
    input  logic        clk_pix,
    input  logic        rst,
    sun_path_if.slave   bus
);
    typedef enum logic [1:0] {IDLE = 2'd0, RISE = 2'd1, HOLD = 2'd2, SET = 2'd3} state_t;

    localparam int SXW = XW + 1;
    localparam int SYW = YW + 1;
    localparam int DXW = XW + 2;
    localparam int DYW = YW + 2;
    localparam int D2W = 2*DXW + 1;
    localparam int CW  = $clog2((HOLD_STEPS > RISE_STEPS ? HOLD_STEPS : RISE_STEPS) + 1);

    localparam logic signed [SXW-1:0] X0_L  = SXW'(START_X);
    localparam logic signed [SXW-1:0] X0_R  = SXW'(H_RES - START_X);
    localparam logic signed [SYW-1:0] Y0    = SYW'(HORIZON_Y);
    localparam logic signed [SYW-1:0] V_LIM = SYW'(V_RES);
    localparam logic [D2W-1:0]        R2    = D2W'(RADIUS*RADIUS);
`ifdef SUN_HALO_EN
    localparam logic [D2W-1:0]        H2    = D2W'((RADIUS+HALO_W)*(RADIUS+HALO_W));
`endif

    state_t                state, state_n;
    logic                  done_r, done_n;
    logic signed [SXW-1:0] sun_x;
    logic signed [SYW-1:0] sun_y;
    logic                  dir_l;
    logic [3:0]            speed_l, div;
    logic [CW-1:0]         cnt;
    logic                  busy, tick, last;

    assign busy = (state != IDLE);
    assign tick = busy && bus.frame && (div == speed_l);
    assign last = (state == HOLD) ? (cnt == CW'(HOLD_STEPS-1)) : (cnt == CW'(RISE_STEPS-1));

    always_ff @(posedge clk_pix or posedge rst) begin
        if (rst) begin
            state  <= IDLE;
            done_r <= 1'b0;
        end else begin
            state  <= state_n;
            done_r <= done_n;
        end
    end

    always_comb begin
        state_n = state;
        done_n  = 1'b0;
        case (state)
            IDLE: if (bus.start)   state_n = RISE;
            RISE: if (tick && last) state_n = HOLD;
            HOLD: if (tick && last) state_n = SET;
            SET:  if (tick && last) begin
                state_n = IDLE;
                done_n  = 1'b1;
            end
            default: state_n = IDLE;
        endcase
    end

    // Trajectory only moves on step ticks so a frame never shows two sun positions.
    always_ff @(posedge clk_pix or posedge rst) begin
        if (rst) begin
            sun_x   <= X0_L;
            sun_y   <= Y0;
            dir_l   <= 1'b0;
            speed_l <= '0;
            div     <= '0;
            cnt     <= '0;
        end else if (state == IDLE) begin
            if (bus.start) begin
                dir_l   <= bus.direction;
                speed_l <= bus.speed;
                div     <= '0;
                cnt     <= '0;
                sun_x   <= bus.direction ? X0_R : X0_L;
                sun_y   <= Y0;
            end
        end else if (bus.frame) begin
            div <= tick ? '0 : div + 4'd1;
            if (tick) begin
                cnt <= last ? '0 : cnt + 1'b1;
                if (state == SET && last) begin
                    sun_x <= dir_l ? X0_R : X0_L;
                    sun_y <= Y0;
                end else begin
                    sun_x <= dir_l ? sun_x + SXW'(STEP_X) : sun_x - SXW'(STEP_X);
                    if (state == RISE)     sun_y <= sun_y - SYW'(STEP_Y);
                    else if (state == SET) sun_y <= sun_y + SYW'(STEP_Y);
                end
            end
        end
    end

    // Pixel pipe: S1 squares the signed offsets, S2 classifies the distance.
    logic signed [DXW-1:0]   dx;
    logic signed [DYW-1:0]   dy;
    logic signed [2*DXW-1:0] dx_w;
    logic signed [2*DYW-1:0] dy_w;
    logic [2*DXW-1:0]        dx2;
    logic [2*DYW-1:0]        dy2;
    logic [D2W-1:0]          dist2;
    logic                    vis1;
    logic [COLRW-1:0]        colr;

    assign dx    = $signed({2'b00, bus.sx}) - $signed({sun_x[SXW-1], sun_x});
    assign dy    = $signed({2'b00, bus.sy}) - $signed({sun_y[SYW-1], sun_y});
    assign dx_w  = {{DXW{dx[DXW-1]}}, dx};
    assign dy_w  = {{DYW{dy[DYW-1]}}, dy};
    assign dist2 = {1'b0, dx2} + {{(D2W-2*DYW){1'b0}}, dy2};

    always_ff @(posedge clk_pix or posedge rst) begin
        if (rst) begin
            dx2  <= '0;
            dy2  <= '0;
            vis1 <= 1'b0;
            colr <= '0;
        end else begin
            dx2  <= dx_w * dx_w;
            dy2  <= dy_w * dy_w;
            vis1 <= busy && (sun_y < V_LIM);
            if (!vis1)              colr <= '0;
            else if (dist2 <= R2)   colr <= COLOR_SUN;
`ifdef SUN_HALO_EN
            else if (dist2 <= H2)   colr <= COLOR_HALO;
`endif
            else                    colr <= '0;
        end
    end

    assign bus.sun_colr = colr;
    assign bus.busy     = busy;
    assign bus.done     = done_r;
    assign bus.phase    = state;
endmodule

// File: tb/tb_sun_path_engine.sv
// Scoreboard bench for sun_path_engine: pixel probes push expected colours, a monitor pops them 2 clk later.
module tb_sun_path_engine;
    logic clk_pix = 1'b0;
    logic rst     = 1'b1;
    always #5 clk_pix = ~clk_pix;

    sun_path_if #(.XW(10), .YW(9), .COLRW(12)) bus();

    sun_path_engine dut (.clk_pix(clk_pix), .rst(rst), .bus(bus));

    int n_vec = 0;
    int n_err = 0;
    int done_cnt = 0;

    logic [11:0] exp_q[$];
    string       tag_q[$];
    logic        probe_now = 1'b0;
    logic [1:0]  pend = 2'b00;

    // reference model state
    bit m_busy = 0;
    bit m_dir  = 0;
    int m_spd  = 0;
    int m_frm  = 0;
    int m_k    = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    function automatic void mpos(input bit d, input int k, output int x, output int y);
        int sg;
        sg = d ? 1 : -1;
        x  = (d ? 0 : 640) + sg*2*k;
        if (k <= 40)       y = 310 - 5*k;
        else if (k <= 200) y = 110;
        else               y = 110 + 5*(k - 200);
    endfunction

    function automatic logic [11:0] mcol(input int px, input int py);
        int x, y, d2;
        mpos(m_dir, m_k, x, y);
        d2 = (px-x)*(px-x) + (py-y)*(py-y);
        if (!m_busy || y >= 480) return 12'h000;
        if (d2 <= 576) return 12'hFF0;
`ifdef SUN_HALO_EN
        if (d2 <= 784) return 12'h860;
`endif
        return 12'h000;
    endfunction

    always @(posedge clk_pix) pend <= {pend[0], probe_now};

    always @(negedge clk_pix) begin
        if (bus.done === 1'b1) done_cnt++;
        if (pend[1]) begin
            if (exp_q.size() == 0) check("sb_underflow", 1, 0);
            else check(tag_q.pop_front(), {20'd0, bus.sun_colr}, {20'd0, exp_q.pop_front()});
        end
    end

    task automatic probe(input int px, input int py);
        @(negedge clk_pix);
        bus.sx = 10'(px);
        bus.sy = 9'(py);
        probe_now = 1'b1;
        exp_q.push_back(mcol(px, py));
        tag_q.push_back($sformatf("px(%0d,%0d)k%0d", px, py, m_k));
        @(posedge clk_pix);
        #1 probe_now = 1'b0;
    endtask

    task automatic flush();
        repeat (4) @(negedge clk_pix);
    endtask

    task automatic do_start(input bit d, input int spd, input bit with_frame);
        @(negedge clk_pix);
        bus.start = 1'b1; bus.direction = d; bus.speed = 4'(spd); bus.frame = with_frame;
        if (!m_busy) begin
            m_busy = 1; m_dir = d; m_spd = spd; m_k = 0; m_frm = 0;
        end
        @(negedge clk_pix);
        bus.start = 1'b0; bus.frame = 1'b0;
    endtask

    task automatic frame_pulse(input int n);
        for (int i = 0; i < n; i++) begin
            @(negedge clk_pix);
            bus.frame = 1'b1;
            if (m_busy) begin
                if (m_frm == m_spd) begin
                    m_frm = 0;
                    m_k++;
                    if (m_k == 240) m_busy = 0;
                end else m_frm++;
            end
            @(negedge clk_pix);
            bus.frame = 1'b0;
        end
    endtask

    task automatic pulse_reset();
        @(negedge clk_pix);
        #2 rst = 1'b1;
        m_busy = 0; m_k = 0; m_frm = 0;
        @(negedge clk_pix);
        rst = 1'b0;
    endtask

    initial begin
        bus.frame = 0; bus.sx = '0; bus.sy = '0; bus.start = 0; bus.direction = 0; bus.speed = '0;
        repeat (3) @(negedge clk_pix);
        check("rst_colr",  {20'd0, bus.sun_colr}, 0);
        check("rst_busy",  {31'd0, bus.busy}, 0);
        check("rst_done",  {31'd0, bus.done}, 0);
        check("rst_phase", {30'd0, bus.phase}, 0);
        rst = 1'b0;
        probe(640, 310);
        flush();

        // start coinciding with a frame pulse must not step
        do_start(0, 0, 1);
        check("start_phase", {30'd0, bus.phase}, 1);
        check("start_busy",  {31'd0, bus.busy}, 1);
        probe(640, 310); probe(640, 286); probe(640, 285);
        flush();

        frame_pulse(40);
        check("rise_end_phase", {30'd0, bus.phase}, 2);
        probe(560, 110); probe(585, 110); probe(584, 110);
        probe(587, 110); probe(589, 110); probe(560, 134); probe(560, 135);
        flush();

        frame_pulse(10);
        @(negedge clk_pix);
        #2 rst = 1'b1;
        #1;
        check("midrst_colr",  {20'd0, bus.sun_colr}, 0);
        check("midrst_busy",  {31'd0, bus.busy}, 0);
        check("midrst_phase", {30'd0, bus.phase}, 0);
        m_busy = 0; m_k = 0; m_frm = 0;
        @(negedge clk_pix);
        rst = 1'b0;
        frame_pulse(1);
        for (int y = 0; y < 480; y += 16)
            for (int x = 0; x < 640; x += 16) probe(x, y);
        for (int y = 90; y <= 130; y += 4)
            for (int x = 520; x <= 560; x += 4) probe(x, y);
        flush();

        // full run, direction 0, speed 0
        done_cnt = 0;
        do_start(0, 0, 0);
        frame_pulse(239);
        check("pre_done_phase", {30'd0, bus.phase}, 3);
        check("pre_done_cnt",   32'(done_cnt), 0);
        probe(162, 305); probe(162, 329); probe(162, 330);
        flush();
        frame_pulse(1);
        repeat (3) @(negedge clk_pix);
        check("done_cnt",   32'(done_cnt), 1);
        check("end_busy",   {31'd0, bus.busy}, 0);
        check("end_phase",  {30'd0, bus.phase}, 0);
        probe(160, 310); probe(640, 310);
        flush();

        // speed 2: one step per three frames; start while busy is ignored
        do_start(0, 2, 0);
        frame_pulse(2);
        probe(640, 286); probe(640, 282);
        frame_pulse(1);
        probe(640, 282); probe(638, 281); probe(638, 280);
        flush();
        do_start(1, 0, 0);
        check("busy_start_phase", {30'd0, bus.phase}, 1);
        frame_pulse(2);
        probe(638, 281); probe(636, 276);
        frame_pulse(1);
        probe(636, 276); probe(636, 300); probe(638, 305);
        flush();
        pulse_reset();

        // direction 1
        do_start(1, 0, 0);
        frame_pulse(40);
        probe(80, 110); probe(104, 110); probe(105, 110); probe(56, 110);
        flush();
        frame_pulse(160);
        check("dir1_set_phase", {30'd0, bus.phase}, 3);
        probe(400, 110); probe(424, 110); probe(425, 110); probe(398, 110);
        flush();

        check("sb_empty", 32'(exp_q.size()), 0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
